netwalk_grant_arbiter: RTL
==========================

Name: netwalk_grant_arbiter

Overview:
Round-robin arbiter directly upstream of netwalk_encoder. Takes 64 level-sensitive request lines from the netwalk lookup slots. Produces a registered, strictly one-hot grant vector that feeds encoder_in, plus a valid/ack handshake. A grant is held stable until the consumer acknowledges it or a timeout expires. Downstream logic qualifies the encoder output with grant_valid, because the encoder maps all-zero input to 6'b111111.

Parameters:
ENCODER_OUT_WIDTH, 6, index width; must match the downstream encoder.
REQ_WIDTH, 1<<ENCODER_OUT_WIDTH (derived, not overridden), number of request/grant lines.
TIMEOUT_CYCLES, 255, maximum cycles a grant waits for ack before it is revoked; range 1..2^TO_WIDTH-1.
TO_WIDTH, 8, timeout counter width.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
req_in  input  REQ_WIDTH  request lines; bit i = requester i; any number may be set.
grant_ack  input  1  consumer has taken the current grant; sampled only while grant_valid=1.
grant_out  output  REQ_WIDTH  registered one-hot grant; all-zero when grant_valid=0.
grant_valid  output  1  grant_out holds a live grant.
timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.
idle  output  1  high in IDLE state.

Behaviour:
- Reset (reset=0, asynchronous): grant_out=0, grant_valid=0, timeout_pulse=0, idle=1, ptr=0, to_cnt=0, state=IDLE. Effective immediately, including mid-grant.
- State ptr[ENCODER_OUT_WIDTH-1:0]: search start index.
- Pick function: winner = lowest i >= ptr with req_in[i]=1; if none, lowest i < ptr with req_in[i]=1.
- States: IDLE, GRANT.
- IDLE:
  - If |req_in on a posedge: grant_out <= onehot(winner), grant_valid <= 1, to_cnt <= 0, go GRANT. Latency is one clock from request to grant_valid.
  - If no request: stay IDLE, outputs zero.
  - grant_ack is ignored in IDLE.
- GRANT:
  - grant_out is frozen regardless of req_in changes, including the granted requester dropping its request.
  - to_cnt increments each cycle.
  - grant_ack=1: ptr <= (granted index + 1) mod REQ_WIDTH, so 63 wraps to 0.
    - If any req_in bit other than the granted bit is set, re-pick in the same cycle using the new ptr, load the new grant, clear to_cnt, and stay in GRANT. This gives back-to-back grants with no bubble.
    - Otherwise grant_out <= 0, grant_valid <= 0, go IDLE.
  - grant_ack=0 and to_cnt == TIMEOUT_CYCLES-1: revoke the grant (grant_out <= 0, grant_valid <= 0), timeout_pulse <= 1 for one cycle, ptr advances as for ack, go IDLE. No same-cycle re-grant on timeout.
  - ack and timeout in the same cycle: ack wins; no timeout_pulse.
- Invariant: grant_out is either zero or exactly one-hot; grant_valid == |grant_out.
- The arbiter never grants a bit whose req_in was 0 at the pick cycle.

Decomposition:
- Shared header netwalk_defs.vh holds NW_IDX_WIDTH=6, NW_VEC_WIDTH=64, state encodings NW_ARB_IDLE=1'b0 and NW_ARB_GRANT=1'b1, and the TIMEOUT default.
- One combinational sub-module, netwalk_rr_pick. Inputs: req vector and ptr. Outputs: one-hot winner, winner index, any. Implementation: rotate right by ptr, priority-pick lowest set bit, rotate back.
- The FSM, ptr and to_cnt stay in the top module.

Test Plan:
- Reset release, req_in=0 for 10 cycles -> grant_valid=0, grant_out=0, idle=1 throughout.
- req_in bits {5,20,40} held, ack every GRANT cycle -> grants 5,20,40,5 on consecutive cycles; encoder output 5,20,40,5.
- ptr=63 (grant 63 then ack), req_in bits {0,63} -> next grant bit 0 (wrap), then 63.
- Grant on bit 7, no ack, TIMEOUT_CYCLES=4 -> grant held 4 cycles, then timeout_pulse for 1 cycle, grant_valid=0; next grant starts from ptr=8.
- Grant on bit 3, req_in[3] drops mid-grant -> grant_out stays 64'h8 until ack; ack with req_in=0 -> IDLE next cycle.
- reset asserted asynchronously mid-GRANT (between clock edges) -> grant_out=0 and grant_valid=0 immediately; after release the first grant searches from ptr=0.

Source files
------------

// File: rtl/netwalk_grant_arbiter_pkg.sv
// Shared constants and state type for the netwalk grant arbiter and its round-robin picker.
package netwalk_grant_arbiter_pkg;

  localparam int NW_IDX_WIDTH         = 6;
  localparam int NW_VEC_WIDTH         = 1 << NW_IDX_WIDTH;
  localparam logic NW_ARB_IDLE        = 1'b0;
  localparam logic NW_ARB_GRANT       = 1'b1;
  localparam int NW_TIMEOUT_DEFAULT   = 255;
  localparam int NW_TO_WIDTH_DEFAULT  = 8;

  typedef enum logic {
    ARB_IDLE  = NW_ARB_IDLE,
    ARB_GRANT = NW_ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/netwalk_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr lands on bit 0, take the
// lowest set bit, then rotate the one-hot result back into place.
module netwalk_rr_pick
  import netwalk_grant_arbiter_pkg::*;
#(
  parameter int IDX_W = NW_IDX_WIDTH,
  localparam int N    = 1 << IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  logic [N-1:0]     rot_req;
  logic [N-1:0]     rot_oh;
  logic [IDX_W-1:0] rot_idx;

  // Index arithmetic is IDX_W bits wide, so the wrap mod N comes for free.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot_req[gi]   = req[IDX_W'(gi) + ptr];
    assign winner_oh[gi] = rot_oh[IDX_W'(gi) - ptr];
  end

  assign rot_oh = rot_req & (~rot_req + N'(1));

  always_comb begin
    rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) rot_idx = IDX_W'(i);
    end
  end

  assign winner_idx = rot_idx + ptr;
  assign any        = |req;

endmodule

// File: rtl/netwalk_grant_arbiter.sv
// Round-robin grant arbiter feeding netwalk_encoder: registered one-hot grant held
// until ack or timeout, with back-to-back re-grant on ack.
module netwalk_grant_arbiter
  import netwalk_grant_arbiter_pkg::*;
#(
  parameter int ENCODER_OUT_WIDTH = NW_IDX_WIDTH,
  parameter int TIMEOUT_CYCLES    = NW_TIMEOUT_DEFAULT,
  parameter int TO_WIDTH          = NW_TO_WIDTH_DEFAULT,
  localparam int REQ_WIDTH        = 1 << ENCODER_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REQ_WIDTH-1:0] req_in,
  input  logic                 grant_ack,
  output logic [REQ_WIDTH-1:0] grant_out,
  output logic                 grant_valid,
  output logic                 timeout_pulse,
  output logic                 idle
);

  localparam int IW = ENCODER_OUT_WIDTH;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [REQ_WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [TO_WIDTH-1:0]  to_cnt_q, to_cnt_d;
  logic                 tpulse_q, tpulse_d;

  logic [IW-1:0]        next_ptr;
  logic [IW-1:0]        pick_ptr;
  logic [REQ_WIDTH-1:0] pick_req;
  logic [REQ_WIDTH-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  assign next_ptr = idx_q + IW'(1);

  // One picker serves both cases: in IDLE it searches from ptr; in GRANT it
  // searches from the post-ack pointer with the current grantee masked out.
  assign pick_ptr = (state_q == ARB_GRANT) ? next_ptr : ptr_q;
  assign pick_req = req_in & ~grant_q;

  netwalk_rr_pick #(.IDX_W(IW)) u_pick (
    .req        (pick_req),
    .ptr        (pick_ptr),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    to_cnt_d = to_cnt_q;
    tpulse_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_oh;
          idx_d    = pick_idx;
          to_cnt_d = '0;
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        if (grant_ack) begin
          ptr_d = next_ptr;
          if (pick_any) begin
            grant_d  = pick_oh;
            idx_d    = pick_idx;
            to_cnt_d = '0;
          end else begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          grant_d  = '0;
          tpulse_d = 1'b1;
          ptr_d    = next_ptr;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      to_cnt_q <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      to_cnt_q <= to_cnt_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign grant_out     = grant_q;
  assign grant_valid   = (state_q == ARB_GRANT);
  assign timeout_pulse = tpulse_q;
  assign idle          = (state_q == ARB_IDLE);

endmodule
